assoc_dcache: RTL and testbench
===============================

# assoc_dcache

Parametrised N-way set-associative write-back data cache between the datapath (`datapath_cache_if.cache`) and the memory controller (`caches_if.dcache`). It generalises set count, associativity and block size, and uses tree pseudo-LRU replacement. It handles multi-word write-back and fill through an explicit FSM. On halt it flushes every dirty line to memory, then writes the hit count to 0x3100 and raises `flushed`.

## Interface
- `SETS`, 8, number of sets, power of 2, ≥2
- `WAYS`, 2, associativity, power of 2, ≥2
- `WORDS`, 2, 32-bit words per block, power of 2, ≥1
- `CLK` in 1: clock; all state updates on posedge
- `nRST` in 1: reset, asynchronous, active-low
- `dcif.halt` in 1: datapath halted; request flush
- `dcif.dmemREN` in 1: load request
- `dcif.dmemWEN` in 1: store request
- `dcif.dmemaddr` in 32: byte address, word aligned
- `dcif.dmemstore` in 32: store data
- `dcif.dhit` out 1: request completes this cycle
- `dcif.dmemload` out 32: load data, valid when `dhit`
- `dcif.flushed` out 1: flush and count write complete
- `cif.dREN` out 1: memory word read
- `cif.dWEN` out 1: memory word write
- `cif.daddr` out 32: memory word address
- `cif.dstore` out 32: memory write data
- `cif.dload` in 32: memory read data
- `cif.dwait` in 1: memory busy; a word completes when the request is asserted and `dwait`=0

## Operation
- Address split, LSB first:
  - [1:0] byte, ignored
  - log2(WORDS) word offset
  - log2(SETS) index
  - remainder tag
- Per line: valid, dirty, tag, WORDS data words.
- Per set: WAYS-1 PLRU bits.
- FSM states: IDLE, WB, FILL, FLUSH, CNT, DONE.
- IDLE:
  - Lookup all ways in parallel.
  - Read hit: `dhit`=1 and `dmemload`=hit word, same cycle.
  - Write hit: `dhit`=1; word written and dirty set at posedge.
  - Any hit updates the set's PLRU to point away from the hit way.
  - Miss: `dhit`=0. Select victim = PLRU way, or the lowest-numbered invalid way if one exists.
  - Miss next state: WB if the victim is valid and dirty, else FILL.
  - REN and WEN both high: treated as store.
- WB:
  - `cif.dWEN`=1, `daddr`={victim tag, index, w, 2'b00}, `dstore`=victim word w.
  - w = 0..WORDS-1; w advances when `dwait`=0.
  - After the last word: clear dirty, go to FILL.
- FILL:
  - `cif.dREN`=1, `daddr`={req tag, index, w, 2'b00}.
  - On `dwait`=0, latch `dload` into victim word w.
  - After the last word: set valid=1, dirty=0, tag, return to IDLE.
  - The retried lookup then hits, and a store merges on that hit.
- Hit counter (32 b):
  - Increments on `dhit` only if the request did not miss first.
  - A "missed" flag is set on the IDLE→miss exit and cleared on `dhit`.
- Halt:
  - `halt`=1 is sampled in IDLE only and takes priority over a pending request.
  - An in-flight WB/FILL completes first.
- FLUSH:
  - Scan the line counter 0..SETS·WAYS-1.
  - Valid and dirty line: write its WORDS words as in WB, clear dirty.
  - Clean or invalid line: skip in 1 cycle.
- CNT: `cif.dWEN`=1, `daddr`=0x3100, `dstore`=hit counter; held until `dwait`=0.
- DONE:
  - `flushed`=1, all other requests deasserted.
  - Leaves DONE only on reset.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - All valid/dirty/PLRU bits 0; hit counter 0; word and line counters 0.
- Hit latency: 0 cycles (combinational `dhit`).
- Clean miss latency: 1 + WORDS·(memory latency), then 1 hit cycle.
- Dirty miss adds WORDS more memory words.
- Memory handshake:
  - `daddr`/`dstore`/`dREN`/`dWEN` stay stable while `dwait`=1.
  - Never assert `dREN` and `dWEN` together.
  - Outputs drop in the cycle after the last word.
- `dwait` stuck high: the FSM holds its state indefinitely, with no timeout.
- Asynchronous reset mid-WB/FILL/FLUSH: immediate abort; all lines invalid; no partial state retained.
- `halt` deasserting during FLUSH is ignored; the flush runs to DONE.
- The hit counter wraps at 2^32.

## Structure
- `cache_pkg`:
  - `dcache_state_t` enum (IDLE, WB, FILL, FLUSH, CNT, DONE).
  - Constant `HIT_CNT_ADDR`=32'h3100.
- Sub-module `dcache_plru` (params SETS, WAYS):
  - Per-set tree bits.
  - Inputs: index, update strobe, hit way.
  - Output: victim way for the index.
  - Asynchronous reset to 0.

## Test plan
- Cold read 0x0000_0040 (WORDS=2, memory latency 2): 2-word FILL at 0x40 and 0x44, then `dhit` with the memory value; hit counter stays 0.
- Write hit after a fill: store 0xDEADBEEF to 0x44 → `dhit` same cycle; a subsequent read returns 0xDEADBEEF; the line is dirty.
- WAYS=2: fill set 0 from tags A and B, touch A, then miss on tag C → B evicted; A still hits.
- Dirty eviction with tag B at 0x80: WB writes 0x80 and 0x84, then FILL, with no `dREN`/`dWEN` overlap.
- Halt with 3 dirty lines and 5 hits: exactly 3·WORDS data writes, then a write to 0x3100 with data 5, then `flushed`=1 held.
- Reset asserted during WB with `dwait`=1: outputs 0 immediately; after release, the old address misses.
- Regress with `SETS`=16, `WAYS`=4, `WORDS`=4.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the associative data cache.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FILL,
        FLUSH,
        CNT,
        DONE
    } dcache_state_t;

    localparam logic [31:0] HIT_CNT_ADDR = 32'h0000_3100;

endpackage

// File: rtl/dcache_plru.sv
// Tree pseudo-LRU state, one tree of WAYS-1 bits per set.
// Node n has children 2n (bit 0) and 2n+1 (bit 1); each bit points toward the victim side.
module dcache_plru #(
    parameter int SETS = 8,
    parameter int WAYS = 2
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [$clog2(SETS)-1:0] i_index,
    input  logic                    i_update,
    input  logic [$clog2(WAYS)-1:0] i_hit_way,
    output logic [$clog2(WAYS)-1:0] o_victim
);

    localparam int WAY_W = $clog2(WAYS);

    // Bit 0 of each tree is never a node; it only keeps the node index equal to the bit index.
    logic [WAYS-1:0] r_tree [SETS];
    logic [WAYS-1:0] w_cur;
    logic [WAYS-1:0] w_next;

    assign w_cur = r_tree[i_index];

    always_comb begin
        logic [WAY_W:0] node;
        node = (WAY_W+1)'(1);
        for (int l = 0; l < WAY_W; l++)
            node = {node[WAY_W-1:0], w_cur[node[WAY_W-1:0]]};
        o_victim = node[WAY_W-1:0];
    end

    always_comb begin
        logic [WAY_W:0] node;
        w_next = w_cur;
        node   = (WAY_W+1)'(1);
        for (int l = 0; l < WAY_W; l++) begin
            w_next[node[WAY_W-1:0]] = ~i_hit_way[WAY_W-1-l];
            node = {node[WAY_W-1:0], i_hit_way[WAY_W-1-l]};
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < SETS; s++)
                r_tree[s] <= '0;
        end else if (i_update) begin
            r_tree[i_index] <= w_next;
        end
    end

endmodule

// File: rtl/assoc_dcache.sv
// N-way set-associative write-back data cache with PLRU replacement,
// multi-word write-back/fill and a halt-triggered flush plus hit-count write.
module assoc_dcache
    import cache_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        i_halt,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_store,
    output logic        o_dhit,
    output logic [31:0] o_dmem_load,
    output logic        o_flushed,
    output logic        o_dren,
    output logic        o_dwen,
    output logic [31:0] o_daddr,
    output logic [31:0] o_dstore,
    input  logic [31:0] i_dload,
    input  logic        i_dwait
);

    localparam int WOFF_BITS = $clog2(WORDS);
    localparam int WOFF_W    = (WOFF_BITS > 0) ? WOFF_BITS : 1;
    localparam int IDX_W     = $clog2(SETS);
    localparam int WAY_W     = $clog2(WAYS);
    localparam int LINES     = SETS * WAYS;
    localparam int LINE_W    = IDX_W + WAY_W;
    localparam int TAG_W     = 30 - WOFF_BITS - IDX_W;

    function automatic logic [31:0] mk_addr(input logic [TAG_W-1:0]  tag,
                                            input logic [IDX_W-1:0]  idx,
                                            input logic [WOFF_W-1:0] word);
        return (32'(tag) << (2 + WOFF_BITS + IDX_W)) |
               (32'(idx) << (2 + WOFF_BITS)) |
               (32'(word) << 2);
    endfunction

    dcache_state_t r_state;
    dcache_state_t w_state_next;

    // Lines are flattened as {set, way}, which is also the flush scan order.
    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [31:0]       r_data [LINES][WORDS];

    logic [WOFF_W-1:0] r_word;
    logic [LINE_W-1:0] r_line;
    logic [WAY_W-1:0]  r_victim;
    logic              r_missed;
    logic [31:0]       r_hit_cnt;

    logic [WOFF_W-1:0] w_req_word;
    logic [IDX_W-1:0]  w_req_idx;
    logic [TAG_W-1:0]  w_req_tag;
    logic              w_req;
    logic [WAYS-1:0]   w_hit_vec;
    logic [WAYS-1:0]   w_inv_vec;
    logic [WAY_W-1:0]  w_hit_way;
    logic [WAY_W-1:0]  w_inv_way;
    logic [WAY_W-1:0]  w_plru_victim;
    logic [WAY_W-1:0]  w_victim;
    logic [LINE_W-1:0] w_hit_line;
    logic [LINE_W-1:0] w_new_line;
    logic [LINE_W-1:0] w_victim_line;
    logic              w_hit;
    logic              w_dhit;
    logic              w_miss;
    logic              w_word_last;
    logic              w_flush_dirty;
    logic              w_word_xfer;

    assign w_req_word = WOFF_W'((i_dmem_addr >> 2) & 32'(WORDS - 1));
    assign w_req_idx  = IDX_W'(i_dmem_addr >> (2 + WOFF_BITS));
    assign w_req_tag  = TAG_W'(i_dmem_addr >> (2 + WOFF_BITS + IDX_W));
    assign w_req      = i_dmem_ren | i_dmem_wen;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [LINE_W-1:0] w_line;
        assign w_line        = {w_req_idx, WAY_W'(gi)};
        assign w_hit_vec[gi] = r_valid[w_line] && (r_tag[w_line] == w_req_tag);
        assign w_inv_vec[gi] = !r_valid[w_line];
    end

    // Descending scan leaves the lowest-numbered match selected.
    always_comb begin
        w_hit_way = '0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
            if (w_inv_vec[w]) w_inv_way = WAY_W'(w);
        end
    end

    dcache_plru #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_plru (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_index   (w_req_idx),
        .i_update  (w_dhit),
        .i_hit_way (w_hit_way),
        .o_victim  (w_plru_victim)
    );

    assign w_hit         = |w_hit_vec;
    assign w_victim      = (|w_inv_vec) ? w_inv_way : w_plru_victim;
    assign w_hit_line    = {w_req_idx, w_hit_way};
    assign w_new_line    = {w_req_idx, w_victim};
    assign w_victim_line = {w_req_idx, r_victim};
    assign w_dhit        = (r_state == IDLE) && !i_halt && w_req && w_hit;
    assign w_miss        = (r_state == IDLE) && !i_halt && w_req && !w_hit;
    assign w_word_last   = (r_word == WOFF_W'(WORDS - 1));
    assign w_flush_dirty = r_valid[r_line] && r_dirty[r_line];
    assign w_word_xfer   = !i_dwait && ((r_state == WB) || (r_state == FILL) ||
                                        ((r_state == FLUSH) && w_flush_dirty));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_halt)
                    w_state_next = FLUSH;
                else if (w_miss)
                    w_state_next = (r_valid[w_new_line] && r_dirty[w_new_line]) ? WB : FILL;
            end
            WB:    if (w_word_xfer && w_word_last) w_state_next = FILL;
            FILL:  if (w_word_xfer && w_word_last) w_state_next = IDLE;
            FLUSH: begin
                if ((!w_flush_dirty || (w_word_xfer && w_word_last)) &&
                    (r_line == LINE_W'(LINES - 1)))
                    w_state_next = CNT;
            end
            CNT:   if (!i_dwait) w_state_next = DONE;
            DONE:  w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_dhit      = 1'b0;
        o_dmem_load = '0;
        o_flushed   = 1'b0;
        o_dren      = 1'b0;
        o_dwen      = 1'b0;
        o_daddr     = '0;
        o_dstore    = '0;
        case (r_state)
            IDLE: begin
                o_dhit = w_dhit;
                if (w_dhit) o_dmem_load = r_data[w_hit_line][w_req_word];
            end
            WB: begin
                o_dwen   = 1'b1;
                o_daddr  = mk_addr(r_tag[w_victim_line], w_req_idx, r_word);
                o_dstore = r_data[w_victim_line][r_word];
            end
            FILL: begin
                o_dren  = 1'b1;
                o_daddr = mk_addr(w_req_tag, w_req_idx, r_word);
            end
            FLUSH: begin
                if (w_flush_dirty) begin
                    o_dwen   = 1'b1;
                    o_daddr  = mk_addr(r_tag[r_line], r_line[LINE_W-1:WAY_W], r_word);
                    o_dstore = r_data[r_line][r_word];
                end
            end
            CNT: begin
                o_dwen   = 1'b1;
                o_daddr  = HIT_CNT_ADDR;
                o_dstore = r_hit_cnt;
            end
            DONE:    o_flushed = 1'b1;
            default: ;
        endcase
    end

    // A hit that retries a miss is not counted; r_missed remembers the miss.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_word    <= '0;
            r_line    <= '0;
            r_victim  <= '0;
            r_missed  <= 1'b0;
            r_hit_cnt <= '0;
            r_valid   <= '0;
            r_dirty   <= '0;
        end else begin
            if (w_miss) begin
                r_victim <= w_victim;
                r_missed <= 1'b1;
            end
            if (w_dhit) begin
                r_missed <= 1'b0;
                if (!r_missed) r_hit_cnt <= r_hit_cnt + 32'd1;
                if (i_dmem_wen) r_dirty[w_hit_line] <= 1'b1;
            end
            if (w_word_xfer)
                r_word <= w_word_last ? '0 : r_word + 1'b1;
            case (r_state)
                WB: begin
                    if (w_word_xfer && w_word_last) r_dirty[w_victim_line] <= 1'b0;
                end
                FILL: begin
                    if (w_word_xfer && w_word_last) begin
                        r_valid[w_victim_line] <= 1'b1;
                        r_dirty[w_victim_line] <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (!w_flush_dirty || (w_word_xfer && w_word_last)) begin
                        r_line <= r_line + 1'b1;
                        if (w_flush_dirty) r_dirty[r_line] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_dhit && i_dmem_wen)
            r_data[w_hit_line][w_req_word] <= i_dmem_store;
        if ((r_state == FILL) && w_word_xfer) begin
            r_data[w_victim_line][r_word] <= i_dload;
            if (w_word_last) r_tag[w_victim_line] <= w_req_tag;
        end
    end

endmodule

// File: tb/tb_assoc_dcache.sv
// Directed bench for assoc_dcache (8 sets, 2 ways, 2 words) against a 2-cycle memory model.
module tb_assoc_dcache;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        halt, ren, wen;
    logic [31:0] addr, store;
    logic        o_dhit, o_flushed, o_dren, o_dwen;
    logic [31:0] o_dmem_load, o_daddr, o_dstore;
    logic [31:0] dload;
    logic        dwait;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:4095];
    int          wcnt = 0;
    bit          stuck = 1'b0;
    int          overlap = 0;
    logic [31:0] rd_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    always #5 clk = ~clk;

    assoc_dcache #(.SETS(8), .WAYS(2), .WORDS(2)) u_dut (
        .CLK          (clk),
        .nRST         (nrst),
        .i_halt       (halt),
        .i_dmem_ren   (ren),
        .i_dmem_wen   (wen),
        .i_dmem_addr  (addr),
        .i_dmem_store (store),
        .o_dhit       (o_dhit),
        .o_dmem_load  (o_dmem_load),
        .o_flushed    (o_flushed),
        .o_dren       (o_dren),
        .o_dwen       (o_dwen),
        .o_daddr      (o_daddr),
        .o_dstore     (o_dstore),
        .i_dload      (dload),
        .i_dwait      (dwait)
    );

    // Memory: each word takes LAT cycles; stuck holds dwait high.
    assign dwait = (o_dren || o_dwen) && (stuck || (wcnt < LAT - 1));
    assign dload = mem[o_daddr[13:2]];

    always @(posedge clk) begin
        if ((o_dren || o_dwen) && !dwait) begin
            wcnt <= 0;
            if (o_dwen) begin
                mem[o_daddr[13:2]] <= o_dstore;
                wa_q.push_back(o_daddr);
                wd_q.push_back(o_dstore);
            end else begin
                rd_q.push_back(o_daddr);
            end
        end else if (o_dren || o_dwen) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
        if (o_dren && o_dwen) overlap <= overlap + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output int cyc);
        @(negedge clk);
        ren = !wr; wen = wr; addr = a; store = d;
        #1;
        cyc = 0;
        while (!o_dhit && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
        end
        check_val("dhit_seen", 32'(o_dhit), 32'd1);
        rdata = o_dmem_load;
        $display("txn %s addr=%h data=%h cycles=%0d", wr ? "wr" : "rd", a, wr ? d : rdata, cyc);
        @(posedge clk); #1;
        ren = 1'b0; wen = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          cyc;
        int          n;
        logic [31:0] exp_a [7];
        logic [31:0] exp_d [7];

        halt = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; store = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 | (32'(i) << 2);

        repeat (3) @(negedge clk);
        check_val("rst_dhit",    32'(o_dhit), 32'd0);
        check_val("rst_dren",    32'(o_dren), 32'd0);
        check_val("rst_dwen",    32'(o_dwen), 32'd0);
        check_val("rst_flushed", 32'(o_flushed), 32'd0);
        check_val("rst_daddr",   o_daddr, 32'd0);
        check_val("rst_load",    o_dmem_load, 32'd0);
        nrst = 1'b1;

        // Cold read: 2-word fill then hit.
        access(0, 32'h40, 32'h0, rd, cyc);
        check_val("cold_data", rd, 32'hA000_0040);
        check_val("cold_cyc", 32'(cyc), 32'd5);
        check_val("cold_nrd", 32'(rd_q.size()), 32'd2);
        check_val("cold_rd0", rd_q[0], 32'h40);
        check_val("cold_rd1", rd_q[1], 32'h44);

        access(1, 32'h44, 32'hDEAD_BEEF, rd, cyc);
        check_val("wrhit_cyc", 32'(cyc), 32'd0);
        access(0, 32'h44, 32'h0, rd, cyc);
        check_val("rdback_data", rd, 32'hDEAD_BEEF);
        check_val("rdback_cyc", 32'(cyc), 32'd0);

        // Set 0: A=0x40 (way0), B=0x80 dirty (way1); touch A; C=0xC0 evicts B.
        access(1, 32'h80, 32'h1111_1111, rd, cyc);
        check_val("wrmiss_cyc", 32'(cyc), 32'd5);
        access(0, 32'h40, 32'h0, rd, cyc);
        check_val("touchA_cyc", 32'(cyc), 32'd0);
        n = wa_q.size();
        access(0, 32'hC0, 32'h0, rd, cyc);
        check_val("evict_cyc", 32'(cyc), 32'd9);
        check_val("evict_data", rd, 32'hA000_00C0);
        check_val("evict_nwr", 32'(wa_q.size() - n), 32'd2);
        check_val("wb_a0", wa_q[n], 32'h80);
        check_val("wb_d0", wd_q[n], 32'h1111_1111);
        check_val("wb_a1", wa_q[n+1], 32'h84);
        check_val("wb_d1", wd_q[n+1], 32'hA000_0084);
        check_val("fill_after_wb", rd_q[rd_q.size()-2], 32'hC0);
        access(0, 32'h44, 32'h0, rd, cyc);
        check_val("A_still_hits", 32'(cyc), 32'd0);
        check_val("A_data", rd, 32'hDEAD_BEEF);
        access(0, 32'h80, 32'h0, rd, cyc);
        check_val("B_evicted_cyc", 32'(cyc), 32'd5);
        check_val("B_wb_data", rd, 32'h1111_1111);

        // Two more dirty lines and a fifth counted hit.
        access(1, 32'h08, 32'h2222_2222, rd, cyc);
        access(1, 32'h10, 32'h3333_3333, rd, cyc);
        access(0, 32'h0C, 32'h0, rd, cyc);
        check_val("hit5_cyc", 32'(cyc), 32'd0);
        check_val("hit5_data", rd, 32'hA000_000C);

        // Halt: flush lines 0, 2, 4 in order, then the hit count.
        exp_a = '{32'h40, 32'h44, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h3100};
        exp_d = '{32'hA000_0040, 32'hDEAD_BEEF, 32'h2222_2222, 32'hA000_000C,
                  32'h3333_3333, 32'hA000_0014, 32'd5};
        n = wa_q.size();
        @(negedge clk);
        halt = 1'b1;
        for (int k = 0; k < 500 && !o_flushed; k++) @(negedge clk);
        check_val("flushed", 32'(o_flushed), 32'd1);
        check_val("flush_nwr", 32'(wa_q.size() - n), 32'd7);
        if (wa_q.size() - n == 7) begin
            for (int k = 0; k < 7; k++) begin
                check_val($sformatf("flush_a%0d", k), wa_q[n+k], exp_a[k]);
                check_val($sformatf("flush_d%0d", k), wd_q[n+k], exp_d[k]);
            end
        end
        halt = 1'b0;
        repeat (3) @(negedge clk);
        check_val("flushed_held", 32'(o_flushed), 32'd1);
        check_val("done_quiet", 32'({o_dren, o_dwen}), 32'd0);
        $display("txn halt flush writes=%0d", wa_q.size() - n);

        // Reset mid-WB with memory stalled.
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        check_val("post_rst_flushed", 32'(o_flushed), 32'd0);
        access(1, 32'h40, 32'h5555_5555, rd, cyc);
        access(1, 32'h80, 32'h6666_6666, rd, cyc);
        stuck = 1'b1;
        @(negedge clk);
        ren = 1'b1; addr = 32'hC0;
        repeat (4) @(negedge clk);
        #1;
        check_val("stall_dwen", 32'(o_dwen), 32'd1);
        check_val("stall_dren", 32'(o_dren), 32'd0);
        check_val("stall_daddr", o_daddr, 32'h40);
        check_val("stall_dstore", o_dstore, 32'h5555_5555);
        #2 nrst = 1'b0;
        #1;
        check_val("abort_dwen", 32'(o_dwen), 32'd0);
        check_val("abort_daddr", o_daddr, 32'd0);
        check_val("abort_dstore", o_dstore, 32'd0);
        $display("txn reset during wb");
        @(negedge clk);
        ren = 1'b0; stuck = 1'b0; nrst = 1'b1;
        access(0, 32'h40, 32'h0, rd, cyc);
        check_val("post_abort_miss", 32'(cyc), 32'd5);
        check_val("post_abort_data", rd, 32'hA000_0040);

        check_val("no_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
